hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_mc_timer.sv | 47 ++++
 rtl/hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//
// Contents:
//   state_e       : controller FSM encoding (INIT, RUN, MC_BUSY, MISS)
//   STG_*         : bit index of each pipeline stage in bubble/flush vectors
//   load_use_hit  : load-use dependency detector between ID and EX
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_MC_BUSY = 2'd2,
      ST_MISS    = 2'd3
   } state_e;

   localparam int STG_F   = 0;
   localparam int STG_D   = 1;
   localparam int STG_E   = 2;
   localparam int STG_M   = 3;
   localparam int STG_W   = 4;
   localparam int NUM_STG = 5;

   // A load in EX writing a non-zero register that ID actually reads.
   function automatic logic load_use_hit(
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       rs1_use,
      input logic       rs2_use,
      input logic [4:0] rd,
      input logic       reg_write_en,
      input logic       wb_select
   );
      logic match_s;
      match_s = (rs1_use & (rs1 == rd)) | (rs2_use & (rs2 == rd));
      return wb_select & reg_write_en & (rd != 5'd0) & match_s;
   endfunction

endpackage

// File: rtl/hazard_mc_timer.sv
// hazard_mc_timer -- loadable down-counter tracking remaining multi-cycle
// EX stall cycles.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value loaded
//   dec_i       : decrement by one; when low (and no load) the count holds
//   zero_o      : count is zero
module hazard_mc_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, decrement (saturating at zero) or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hold/clear sequencing for the 5-stage RV32I pipeline.
//
// Drives bubble (hold) and flush (clear) of the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. Outputs are Mealy: decoded from the FSM state and the
// current hazard inputs in the same cycle.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rs1_D, rs2_D, rs1_use_D,
//   rs2_use_D                     : ID source registers and their use flags
//   rd_E, reg_write_en_E,
//   wb_select_E                   : EX destination, write enable, load flag
//   br_taken_E, jalr_E            : EX redirect
//   jal_D                         : jal decoded in ID
//   mc_start_E                    : multi-cycle op present in EX
//   miss_M                        : data cache miss/busy (level)
//   bubble{F,D,E,M,W}             : hold stage register
//   flush{F,D,E,M,W}              : clear stage register
//   stall_cnt, flush_cnt          : performance counters (only with
//                                   HAZARD_PERF_CNT_EN defined)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int INIT_CYCLES = 2,
   parameter int MC_LAT      = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic             rs1_use_D,
   input  logic             rs2_use_D,
   input  logic [4:0]       rd_E,
   input  logic             reg_write_en_E,
   input  logic             wb_select_E,
   input  logic             br_taken_E,
   input  logic             jalr_E,
   input  logic             jal_D,
   input  logic             mc_start_E,
   input  logic             miss_M,
   output logic             bubbleF,
   output logic             bubbleD,
   output logic             bubbleE,
   output logic             bubbleM,
   output logic             bubbleW,
   output logic             flushF,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int MC_W   = $clog2(MC_LAT);

   state_e              state_q;
   state_e              state_d;
   logic [INIT_W-1:0]   init_cnt_q;
   logic [INIT_W-1:0]   init_cnt_d;

   logic                lu_s;
   logic                redirect_s;
   logic [NUM_STG-1:0]  base_bubble_s;
   logic [NUM_STG-1:0]  base_flush_s;
   logic [NUM_STG-1:0]  bubble_s;
   logic [NUM_STG-1:0]  flush_s;
   logic                mc_load_s;
   logic                mc_dec_s;
   logic                mc_zero_s;

   assign lu_s       = load_use_hit(rs1_D, rs2_D, rs1_use_D, rs2_use_D,
                                    rd_E, reg_write_en_E, wb_select_E);
   assign redirect_s = br_taken_E | jalr_E;

   // Redirect / jal / load-use outputs, shared by RUN, MISS exit and
   // the MC_BUSY release cycle.
   always_comb begin
      base_bubble_s = {NUM_STG{1'b0}};
      base_flush_s  = {NUM_STG{1'b0}};
      if (redirect_s) begin
         // The instruction in ID is on the wrong path, so a load-use
         // stall against it is pointless.
         base_flush_s[STG_D] = 1'b1;
         base_flush_s[STG_E] = 1'b1;
      end else begin
         if (lu_s) begin
            base_bubble_s[STG_F] = 1'b1;
            base_bubble_s[STG_D] = 1'b1;
            base_flush_s[STG_E]  = 1'b1;
         end else begin
            base_flush_s[STG_E]  = 1'b0;
         end
         if (jal_D) begin
            // Clearing IF/ID takes precedence over holding it.
            base_flush_s[STG_D]  = 1'b1;
            base_bubble_s[STG_D] = 1'b0;
         end else begin
            base_flush_s[STG_D]  = 1'b0;
         end
      end
   end

   // FSM next state, init counter, mc timer controls and stage outputs.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      bubble_s   = {NUM_STG{1'b0}};
      flush_s    = {NUM_STG{1'b0}};
      mc_load_s  = 1'b0;
      mc_dec_s   = 1'b0;
      case (state_q)
         ST_INIT: begin
            flush_s = {NUM_STG{1'b1}};
            if (init_cnt_q > INIT_W'(1)) begin
               init_cnt_d = init_cnt_q - INIT_W'(1);
               state_d    = ST_INIT;
            end else begin
               init_cnt_d = {INIT_W{1'b0}};
               state_d    = ST_RUN;
            end
         end
         ST_RUN, ST_MISS: begin
            // MISS falls through to RUN rules the cycle miss_M drops.
            if (miss_M) begin
               bubble_s = {NUM_STG{1'b1}};
               state_d  = ST_MISS;
            end else if (mc_start_E) begin
               bubble_s[STG_F] = 1'b1;
               bubble_s[STG_D] = 1'b1;
               bubble_s[STG_E] = 1'b1;
               flush_s[STG_M]  = 1'b1;
               mc_load_s       = 1'b1;
               state_d         = ST_MC_BUSY;
            end else begin
               bubble_s = base_bubble_s;
               flush_s  = base_flush_s;
               state_d  = ST_RUN;
            end
         end
         ST_MC_BUSY: begin
            if (miss_M) begin
               bubble_s = {NUM_STG{1'b1}};
               state_d  = ST_MC_BUSY;
            end else if (!mc_zero_s) begin
               bubble_s[STG_F] = 1'b1;
               bubble_s[STG_D] = 1'b1;
               bubble_s[STG_E] = 1'b1;
               flush_s[STG_M]  = 1'b1;
               mc_dec_s        = 1'b1;
               state_d         = ST_MC_BUSY;
            end else begin
               // Release cycle: mc_start_E is still asserted by the frozen
               // EX stage and must not restart the stall.
               bubble_s = base_bubble_s;
               flush_s  = base_flush_s;
               state_d  = ST_RUN;
            end
         end
         default: begin
            flush_s    = {NUM_STG{1'b1}};
            init_cnt_d = INIT_W'(INIT_CYCLES);
            state_d    = ST_INIT;
         end
      endcase
   end

   // State and init counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= INIT_W'(INIT_CYCLES);
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // The first stall cycle is issued from RUN, so MC_LAT-2 more remain.
   hazard_mc_timer #(
      .W (MC_W)
   ) u_mc_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (mc_load_s),
      .load_val_i (MC_W'(MC_LAT - 2)),
      .dec_i      (mc_dec_s),
      .zero_o     (mc_zero_s)
   );

   assign bubbleF = bubble_s[STG_F];
   assign bubbleD = bubble_s[STG_D];
   assign bubbleE = bubble_s[STG_E];
   assign bubbleM = bubble_s[STG_M];
   assign bubbleW = bubble_s[STG_W];
   assign flushF  = flush_s[STG_F];
   assign flushD  = flush_s[STG_D];
   assign flushE  = flush_s[STG_E];
   assign flushM  = flush_s[STG_M];
   assign flushW  = flush_s[STG_W];

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   // Count stall and ID-flush cycles outside INIT; wraps naturally.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != ST_INIT) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(bubble_s[STG_F]);
         flush_cnt_d = flush_cnt_q + CNT_W'(flush_s[STG_D]);
      end else begin
         stall_cnt_d = stall_cnt_q;
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Output vector layout used for expectations:
//   {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
//    flushF,  flushD,  flushE,  flushM,  flushW}
// Optional macro HAZARD_PERF_CNT_EN enables the performance counter test.
module tb_hazard_ctrl;

   localparam logic [9:0] EXP_NONE  = 10'b00000_00000;
   localparam logic [9:0] EXP_FALL  = 10'b00000_11111;
   localparam logic [9:0] EXP_BALL  = 10'b11111_00000;
   localparam logic [9:0] EXP_LU    = 10'b11000_00100;
   localparam logic [9:0] EXP_MC    = 10'b11100_00010;
   localparam logic [9:0] EXP_RED   = 10'b00000_01100;
   localparam logic [9:0] EXP_JAL   = 10'b00000_01000;
   localparam logic [9:0] EXP_JALLU = 10'b10000_01100;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       wbs;
      logic       br;
      logic       jalr;
      logic       jal;
      logic       mc;
      logic       miss;
      logic [9:0] exp;
   } row_t;

   logic       clk;
   logic       rst;
   logic [4:0] rs1_D, rs2_D, rd_E;
   logic       rs1_use_D, rs2_use_D, reg_write_en_E, wb_select_E;
   logic       br_taken_E, jalr_E, jal_D, mc_start_E, miss_M;
   logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
   logic       flushF, flushD, flushE, flushM, flushW;
   logic [9:0] outs_s;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   row_t       tbl_q[$];
   logic [9:0] sb_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   hazard_ctrl #(
      .INIT_CYCLES (2),
      .MC_LAT      (4),
      .CNT_W       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rs1_D          (rs1_D),
      .rs2_D          (rs2_D),
      .rs1_use_D      (rs1_use_D),
      .rs2_use_D      (rs2_use_D),
      .rd_E           (rd_E),
      .reg_write_en_E (reg_write_en_E),
      .wb_select_E    (wb_select_E),
      .br_taken_E     (br_taken_E),
      .jalr_E         (jalr_E),
      .jal_D          (jal_D),
      .mc_start_E     (mc_start_E),
      .miss_M         (miss_M),
      .bubbleF        (bubbleF),
      .bubbleD        (bubbleD),
      .bubbleE        (bubbleE),
      .bubbleM        (bubbleM),
      .bubbleW        (bubbleW),
      .flushF         (flushF),
      .flushD         (flushD),
      .flushE         (flushE),
      .flushM         (flushM),
      .flushW         (flushW)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   assign outs_s = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                    flushF, flushD, flushE, flushM, flushW};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers (no checking here).
   task automatic apply(input row_t r);
      rst            = r.rst;
      rs1_D          = r.rs1;
      rs2_D          = r.rs2;
      rs1_use_D      = r.u1;
      rs2_use_D      = r.u2;
      rd_E           = r.rd;
      reg_write_en_E = r.we;
      wb_select_E    = r.wbs;
      br_taken_E     = r.br;
      jalr_E         = r.jalr;
      jal_D          = r.jal;
      mc_start_E     = r.mc;
      miss_M         = r.miss;
   endtask

   task automatic add(input row_t r, input int n);
      for (int i = 0; i < n; i++) tbl_q.push_back(r);
   endtask

   function automatic row_t idle(input logic [9:0] e);
      row_t r;
      r     = '0;
      r.exp = e;
      return r;
   endfunction

   function automatic row_t lu_row(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [9:0] e);
      row_t r;
      r     = '0;
      r.rd  = rd;
      r.rs1 = rs1;
      r.rs2 = rs2;
      r.u1  = 1'b1;
      r.u2  = 1'b1;
      r.we  = 1'b1;
      r.wbs = 1'b1;
      r.exp = e;
      return r;
   endfunction

   task automatic test_reset();
      row_t r;
      tbl_q.delete();
      r = idle(EXP_FALL); r.rst = 1'b1;           add(r, 2);
      r = idle(EXP_FALL); r.miss = 1'b1; r.mc = 1'b1; add(r, 2);
      add(idle(EXP_NONE), 2);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL reset row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

   task automatic test_load_use();
      row_t r;
      tbl_q.delete();
      add(lu_row(5'd5, 5'd5, 5'd1, EXP_LU), 1);
      add(idle(EXP_NONE), 1);
      add(lu_row(5'd7, 5'd2, 5'd7, EXP_LU), 1);
      add(lu_row(5'd0, 5'd0, 5'd0, EXP_NONE), 1);
      r = lu_row(5'd5, 5'd5, 5'd5, EXP_NONE); r.wbs = 1'b0; add(r, 1);
      r = lu_row(5'd5, 5'd5, 5'd5, EXP_NONE); r.we = 1'b0;  add(r, 1);
      r = lu_row(5'd5, 5'd5, 5'd5, EXP_NONE); r.u1 = 1'b0; r.u2 = 1'b0; add(r, 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL load_use row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

   task automatic test_multicycle();
      row_t r;
      tbl_q.delete();
      r = idle(EXP_MC); r.mc = 1'b1; add(r, 3);
      r.exp = EXP_NONE;              add(r, 1);
      add(lu_row(5'd3, 5'd3, 5'd0, EXP_LU), 1);
      // mc op and taken branch together: redirect lands on release cycle.
      r = idle(EXP_MC); r.mc = 1'b1; r.br = 1'b1; add(r, 3);
      r.exp = EXP_RED;                            add(r, 1);
      add(idle(EXP_NONE), 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL multicycle row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

   task automatic test_miss();
      row_t r;
      tbl_q.delete();
      // Miss during MC_BUSY with two stall cycles still pending.
      r = idle(EXP_MC);   r.mc = 1'b1;                add(r, 1);
      r = idle(EXP_BALL); r.mc = 1'b1; r.miss = 1'b1; add(r, 5);
      r = idle(EXP_MC);   r.mc = 1'b1;                add(r, 2);
      r.exp = EXP_NONE;                               add(r, 1);
      // Plain miss, then load-use on the exit cycle.
      r = idle(EXP_BALL); r.miss = 1'b1; r.br = 1'b1; r.mc = 1'b1; add(r, 3);
      r = idle(EXP_MC);   r.mc = 1'b1; r.br = 1'b1;   add(r, 3);
      r.exp = EXP_RED;                                add(r, 1);
      r = idle(EXP_BALL); r.miss = 1'b1;              add(r, 2);
      add(lu_row(5'd9, 5'd9, 5'd0, EXP_LU), 1);
      add(idle(EXP_NONE), 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL miss row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

   task automatic test_redirect();
      row_t r;
      tbl_q.delete();
      r = lu_row(5'd5, 5'd5, 5'd0, EXP_RED);   r.br = 1'b1;   add(r, 1);
      r = lu_row(5'd5, 5'd5, 5'd0, EXP_RED);   r.jalr = 1'b1; add(r, 1);
      r = idle(EXP_JAL);                       r.jal = 1'b1;  add(r, 1);
      r = lu_row(5'd6, 5'd0, 5'd6, EXP_JALLU); r.jal = 1'b1;  add(r, 1);
      r = idle(EXP_RED); r.jal = 1'b1; r.br = 1'b1;           add(r, 1);
      add(idle(EXP_NONE), 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL redirect row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t r;
      tbl_q.delete();
      add(lu_row(5'd4, 5'd4, 5'd0, EXP_LU), 1);
      r = idle(EXP_RED); r.jalr = 1'b1; add(r, 1);
      r = idle(EXP_JAL); r.jal = 1'b1;  add(r, 1);
      r = idle(EXP_MC);  r.mc = 1'b1;   add(r, 1);
      add(idle(EXP_MC), 2);
      add(lu_row(5'd8, 5'd8, 5'd0, EXP_LU), 1);
      add(idle(EXP_NONE), 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL back_to_back row %0d: got %b expected %b", i, outs_s, want);
         end
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_cnt();
      row_t r;
      test_reset();
      tbl_q.delete();
      add(lu_row(5'd5, 5'd5, 5'd0, EXP_LU), 1);
      add(idle(EXP_NONE), 1);
      r = idle(EXP_MC); r.mc = 1'b1; add(r, 3);
      r.exp = EXP_NONE;              add(r, 1);
      add(idle(EXP_NONE), 1);
      foreach (tbl_q[i]) begin
         logic [9:0] want;
         @(posedge clk); #1;
         apply(tbl_q[i]);
         sb_q.push_back(tbl_q[i].exp);
         @(negedge clk);
         want = sb_q.pop_front();
         n_cmp++;
         if (outs_s !== want) begin
            n_bad++;
            $display("FAIL perf row %0d: got %b expected %b", i, outs_s, want);
         end
      end
      n_cmp++;
      if (stall_cnt !== 32'd4) begin
         n_bad++;
         $display("FAIL stall_cnt: got %0d expected 4", stall_cnt);
      end
      n_cmp++;
      if (flush_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL flush_cnt: got %0d expected 0", flush_cnt);
      end
   endtask
`endif

   initial begin
      apply(idle(EXP_NONE));
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_multicycle();
      test_miss();
      test_redirect();
      test_back_to_back();
      // Reset again mid-run, from a non-idle state.
      test_reset();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
